chip8_timer_unit: RTL and testbench

Parametrised tick generator and countdown-timer bank for the CHIP-8 core. Divides the system clock into a CPU instruction-rate strobe and a slower timer-rate strobe. Holds NUM_TIMERS down-counters (channel 0 = delay timer, channel 1 = sound timer by convention). Each counter decrements on the timer strobe and is loaded and read by the CPU, with a defined priority when a load and a decrement coincide.

---
 rtl/chip8_timer_unit.sv | 128 ++++++++++++
 tb/tb_chip8_timer_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_timer_unit.sv
// chip8_timer_unit: CPU/timer strobe generator plus a bank of CPU-loadable
// countdown channels (channel 0 = delay timer, channel 1 = sound timer).
module chip8_timer_unit #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int CPU_HZ      = 540,
    parameter int TIMER_HZ    = 60,
    parameter int NUM_TIMERS  = 2,
    parameter int TIMER_WIDTH = 8,
    parameter int SEL_W       = (NUM_TIMERS > 1) ? $clog2(NUM_TIMERS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    output logic                   cpu_tick,
    output logic                   timer_tick,
    input  logic                   wr_en,
    input  logic [SEL_W-1:0]       wr_sel,
    input  logic [TIMER_WIDTH-1:0] wr_data,
    input  logic [SEL_W-1:0]       rd_sel,
    output logic [TIMER_WIDTH-1:0] rd_data,
    output logic [NUM_TIMERS-1:0]  active,
    output logic [NUM_TIMERS-1:0]  expired
);

    localparam int CLKS_PER_CPU  = CLK_HZ / CPU_HZ;
    localparam int CPU_PER_TIMER = CPU_HZ / TIMER_HZ;
    // Each divider counter holds 0..reload, so it needs $clog2(reload+1) bits (at least 1).
    localparam int CPU_CNT_W     = (CLKS_PER_CPU > 1) ? $clog2(CLKS_PER_CPU) : 1;
    localparam int TMR_CNT_W     = (CPU_PER_TIMER > 1) ? $clog2(CPU_PER_TIMER) : 1;
    localparam logic [CPU_CNT_W-1:0] CPU_RELOAD = CPU_CNT_W'(CLKS_PER_CPU - 1);
    localparam logic [TMR_CNT_W-1:0] TMR_RELOAD = TMR_CNT_W'(CPU_PER_TIMER - 1);

    logic [CPU_CNT_W-1:0]   r_cpu_cnt;
    logic [TMR_CNT_W-1:0]   r_tmr_cnt;
    logic                   r_cpu_tick;
    logic                   r_timer_tick;
    logic [TIMER_WIDTH-1:0] r_ch [NUM_TIMERS];
    logic [TIMER_WIDTH-1:0] r_rd_data;
    logic [NUM_TIMERS-1:0]  r_expired;

    logic                   w_cpu_wrap;
    logic                   w_tmr_wrap;
    logic [NUM_TIMERS-1:0]  w_wr_hit;
    logic [NUM_TIMERS-1:0]  w_dec;
    logic [TIMER_WIDTH-1:0] w_rd_val;

    // The timer divider only moves on the cycle the CPU divider wraps, so
    // timer_tick always lands on the same edge as a cpu_tick.
    assign w_cpu_wrap = run && (r_cpu_cnt == '0);
    assign w_tmr_wrap = w_cpu_wrap && (r_tmr_cnt == '0);

    // Per-channel write hit, decrement enable (a load wins over a decrement) and read mux.
    always_comb begin
        w_wr_hit = '0;
        w_dec    = '0;
        w_rd_val = '0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            w_wr_hit[i] = wr_en && (wr_sel == SEL_W'(i));
            w_dec[i]    = w_tmr_wrap && (r_ch[i] != '0) && !w_wr_hit[i];
            if (rd_sel == SEL_W'(i)) begin
                w_rd_val = r_ch[i];
            end
        end
    end

    // Clock dividers: both hold their counts while run is low and resume without restart.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cpu_cnt    <= CPU_RELOAD;
            r_tmr_cnt    <= TMR_RELOAD;
            r_cpu_tick   <= 1'b0;
            r_timer_tick <= 1'b0;
        end else begin
            r_cpu_tick   <= w_cpu_wrap;
            r_timer_tick <= w_tmr_wrap;
            if (run) begin
                r_cpu_cnt <= w_cpu_wrap ? CPU_RELOAD : (r_cpu_cnt - CPU_CNT_W'(1));
            end
            if (w_cpu_wrap) begin
                r_tmr_cnt <= (r_tmr_cnt == '0) ? TMR_RELOAD : (r_tmr_cnt - TMR_CNT_W'(1));
            end
        end
    end

    // Countdown channels: CPU load, else decrement on the timer wrap; zero is sticky.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                r_ch[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                if (w_wr_hit[i]) begin
                    r_ch[i] <= wr_data;
                end else if (w_dec[i]) begin
                    r_ch[i] <= r_ch[i] - TIMER_WIDTH'(1);
                end
            end
        end
    end

    // Registered read port (pre-edge channel value) and 1->0 expiry pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_data <= '0;
            r_expired <= '0;
        end else begin
            r_rd_data <= w_rd_val;
            for (int i = 0; i < NUM_TIMERS; i++) begin
                r_expired[i] <= w_dec[i] && (r_ch[i] == TIMER_WIDTH'(1));
            end
        end
    end

    // Channel-nonzero flags come straight from the channel registers.
    always_comb begin
        active = '0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            active[i] = (r_ch[i] != '0);
        end
    end

    assign cpu_tick   = r_cpu_tick;
    assign timer_tick = r_timer_tick;
    assign rd_data    = r_rd_data;
    assign expired    = r_expired;

endmodule

// File: tb/tb_chip8_timer_unit.sv
// Bench for chip8_timer_unit: directed scenarios followed by random traffic,
// every edge checked against a behavioural model of strobes and channels.
module tb_chip8_timer_unit;

    localparam int NT  = 3;
    localparam int TW  = 8;
    localparam int SW  = 2;
    localparam int CPC = 60 / 12;     // clocks per cpu strobe
    localparam int CPT = 12 / 4;      // cpu strobes per timer strobe

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          run = 1'b0;
    logic          wr_en = 1'b0;
    logic [SW-1:0] wr_sel = '0;
    logic [TW-1:0] wr_data = '0;
    logic [SW-1:0] rd_sel = '0;
    logic          cpu_tick;
    logic          timer_tick;
    logic [TW-1:0] rd_data;
    logic [NT-1:0] active;
    logic [NT-1:0] expired;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    int      edge_no;
    int      run_edges;
    int      m_ch [NT];
    int      m_rd;
    bit      m_cpu;
    bit      m_tmr;
    bit [NT-1:0] m_exp;

    chip8_timer_unit #(
        .CLK_HZ(60), .CPU_HZ(12), .TIMER_HZ(4), .NUM_TIMERS(NT), .TIMER_WIDTH(TW)
    ) dut (
        .clk(clk), .reset(reset), .run(run),
        .cpu_tick(cpu_tick), .timer_tick(timer_tick),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_sel(rd_sel), .rd_data(rd_data),
        .active(active), .expired(expired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        edge_no   = 0;
        run_edges = 0;
        for (int i = 0; i < NT; i++) m_ch[i] = 0;
        m_rd  = 0;
        m_cpu = 1'b0;
        m_tmr = 1'b0;
        m_exp = '0;
    endtask

    // One rising edge of the reference: strobes follow from the count of
    // run-enabled edges since reset; channels from load/decrement rules.
    task automatic model_edge();
        int pre [NT];
        pre = m_ch;
        edge_no++;
        if (int'(rd_sel) < NT) m_rd = pre[rd_sel];
        else                   m_rd = 0;
        m_cpu = 1'b0;
        m_tmr = 1'b0;
        if (run) begin
            run_edges++;
            m_cpu = (run_edges % CPC == 0);
            m_tmr = (run_edges % (CPC * CPT) == 0);
        end
        for (int i = 0; i < NT; i++) begin
            m_exp[i] = 1'b0;
            if (wr_en && int'(wr_sel) == i) begin
                m_ch[i] = int'(wr_data);
            end else if (m_tmr && pre[i] != 0) begin
                m_ch[i] = pre[i] - 1;
                if (m_ch[i] == 0) m_exp[i] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        bit [NT-1:0] m_act;
        for (int i = 0; i < NT; i++) m_act[i] = (m_ch[i] != 0);
        chk("cpu_tick",   32'(cpu_tick),   32'(m_cpu));
        chk("timer_tick", 32'(timer_tick), 32'(m_tmr));
        chk("rd_data",    32'(rd_data),    m_rd);
        chk("active",     32'(active),     32'(m_act));
        chk("expired",    32'(expired),    32'(m_exp));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic run_n(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input int sel, input int data);
        wr_en   = 1'b1;
        wr_sel  = SW'(sel);
        wr_data = TW'(data);
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        model_reset();

        // Held in reset: every output low
        repeat (2) @(posedge clk);
        #1;
        check_all();
        #2 reset = 1'b1;

        // Strobes and countdown of ch0 from 3, ch1 load colliding with a timer edge
        run    = 1'b1;
        rd_sel = 2'd0;
        wr(1, 5);                        // edge 1
        wr(0, 3);                        // edge 2
        run_n(3);                        // edge 5
        chk("first_cpu_tick", 32'(cpu_tick), 32'd1);
        run_n(10);                       // edge 15
        chk("tmr_tick_15", 32'(timer_tick), 32'd1);
        tick();                          // edge 16
        chk("ch0_after_15", 32'(rd_data), 32'd2);
        chk("tick_width", 32'(cpu_tick), 32'd0);
        run_n(3);                        // edge 19
        wr(1, 5);                        // edge 20
        run_n(9);                        // edge 29
        wr(1, 9);                        // edge 30, timer edge
        rd_sel = 2'd1;
        tick();                          // edge 31
        chk("ch1_load_wins", 32'(rd_data), 32'd9);
        rd_sel = 2'd0;
        tick();                          // edge 32
        chk("ch0_after_30", 32'(rd_data), 32'd1);
        run_n(13);                       // edge 45
        chk("exp0_pulse", 32'(expired[0]), 32'd1);
        chk("act0_clear", 32'(active[0]), 32'd0);
        tick();                          // edge 46
        chk("exp0_one_clk", 32'(expired[0]), 32'd0);
        chk("ch0_zero", 32'(rd_data), 32'd0);
        rd_sel = 2'd1;
        tick();                          // edge 47
        chk("ch1_after_45", 32'(rd_data), 32'd8);
        rd_sel = 2'd0;
        run_n(14);                       // edge 61
        chk("ch0_stays_0", 32'(active[0]), 32'd0);

        // Asynchronous reset mid-count with ch0 = 7
        wr(0, 7);
        run_n(2);
        #2 reset = 1'b0;
        #1;
        chk("arst_cpu_tick", 32'(cpu_tick), 32'd0);
        chk("arst_timer_tick", 32'(timer_tick), 32'd0);
        chk("arst_rd_data", 32'(rd_data), 32'd0);
        chk("arst_active", 32'(active), 32'd0);
        chk("arst_expired", 32'(expired), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        #2 reset = 1'b1;

        // Pause of 7 clocks starting at edge 12; ch2 must hold
        run    = 1'b1;
        rd_sel = 2'd2;
        wr(2, 4);                        // edge 1
        run_n(4);                        // edge 5
        chk("rst_first_tick", 32'(cpu_tick), 32'd1);
        run_n(6);                        // edge 11
        run = 1'b0;
        run_n(7);                        // edges 12..18
        chk("pause_no_tick", 32'(cpu_tick), 32'd0);
        chk("pause_ch2_hold", 32'(rd_data), 32'd4);
        run = 1'b1;
        run_n(3);                        // edge 21
        chk("resume_not_yet", 32'(cpu_tick), 32'd0);
        tick();                          // edge 22
        chk("resume_tick_22", 32'(cpu_tick), 32'd1);
        chk("resume_tmr_22", 32'(timer_tick), 32'd1);

        // Out-of-range select, then zero-write to a live channel
        wr(3, 8'hAA);
        rd_sel = 2'd3;
        tick();
        chk("oor_read", 32'(rd_data), 32'd0);
        for (int i = 0; i < NT; i++) begin
            rd_sel = SW'(i);
            tick();
        end
        wr(2, 0);
        chk("zero_wr_active", 32'(active[2]), 32'd0);
        chk("zero_wr_noexp", 32'(expired[2]), 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 800; n++) begin
            run     = ($urandom_range(0, 9) != 0);
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_sel  = SW'($urandom_range(0, 3));
            wr_data = ($urandom_range(0, 1) == 0) ? TW'($urandom_range(0, 4))
                                                  : TW'($urandom_range(0, 255));
            rd_sel  = SW'($urandom_range(0, 3));
            tick();
        end
        wr_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
